pc_sequencer: RTL and testbench

Control sequencer for the CPU program counter block. It turns decoder commands into the per-cycle enables and address-byte operands the program counter consumes on `clock_ph2`. Supported operations are:
- increment;
- absolute jump, with an operand fetch;
- relative branch, with a page-cross fixup;
- vector load (NMI, RESET, IRQ).

It sits between the instruction decoder, the memory read port and the program counter. After reset it automatically boots the PC from the RESET vector.

---
 rtl/pc_seq_pkg.sv | 36 +++
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_branch_calc.sv | 18 +
 rtl/pc_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: decoder commands, vector
// selects, FSM states and the default interrupt/reset vector addresses.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    CmdNop    = 3'd0,
    CmdInc    = 3'd1,
    CmdJmpAbs = 3'd2,
    CmdBranch = 3'd3,
    CmdVector = 3'd4
  } cmd_e;

  typedef enum logic [1:0] {
    VecNmi = 2'd0,
    VecRst = 2'd1,
    VecIrq = 2'd2
  } vec_sel_e;

  typedef enum logic [3:0] {
    StRstLo,
    StRstHi,
    StIdle,
    StInc,
    StFetchLo,
    StFetchHi,
    StBrAdd,
    StBrFix,
    StVecLo,
    StVecHi
  } state_e;

  localparam logic [15:0] VEC_NMI_DEFAULT = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEFAULT = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEFAULT = 16'hFFFE;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between decoder / memory read port / program counter (master side)
// and the sequencer (slave side).
interface pc_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd;
  logic [1:0]  vec_sel;
  logic        br_taken;
  logic [7:0]  br_offset;
  logic [7:0]  PCLin;
  logic [7:0]  PCHin;
  logic [7:0]  data_in;
  logic [15:0] addr_out;
  logic [7:0]  ADLout;
  logic [7:0]  ADHout;
  logic        inc_en;
  logic        PCLin_en;
  logic        PCHin_en;
  logic        ADLin_en;
  logic        ADHin_en;
  logic        busy;
  logic        done;

  modport master (
    output cmd_valid, cmd, vec_sel, br_taken, br_offset, PCLin, PCHin, data_in,
    input  cmd_ready, addr_out, ADLout, ADHout, inc_en, PCLin_en, PCHin_en,
           ADLin_en, ADHin_en, busy, done
  );

  modport slave (
    input  cmd_valid, cmd, vec_sel, br_taken, br_offset, PCLin, PCHin, data_in,
    output cmd_ready, addr_out, ADLout, ADHout, inc_en, PCLin_en, PCHin_en,
           ADLin_en, ADHin_en, busy, done
  );
endinterface

// File: rtl/pc_branch_calc.sv
// Relative-branch arithmetic: new low byte, page-cross detect and the
// corrected high byte used by the fixup cycle.
module pc_branch_calc (
  input  logic [7:0] PCLin,
  input  logic [7:0] PCHin,
  input  logic [7:0] br_offset,
  output logic [7:0] new_lo,
  output logic [7:0] new_hi_fix,
  output logic       page_cross
);
  logic [8:0] sum;

  assign sum    = {1'b0, PCLin} + {1'b0, br_offset};
  assign new_lo = sum[7:0];
  // Carry out of a forward step, or no borrow-back on a backward step.
  assign page_cross = sum[8] ^ br_offset[7];
  assign new_hi_fix = br_offset[7] ? (PCHin - 8'd1) : (PCHin + 8'd1);
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: turns decoder commands into per-cycle PC enables
// and load bytes; boots the PC from the RESET vector after reset.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [15:0] VEC_NMI = VEC_NMI_DEFAULT,
  parameter logic [15:0] VEC_RST = VEC_RST_DEFAULT,
  parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEFAULT
) (
  input logic           clock_ph2,
  input logic           rst,
  pc_sequencer_if.slave bus
);
  state_e      state_q, state_d;
  logic [7:0]  tmp_lo_q, tmp_lo_d;
  logic [7:0]  off_q, off_d;
  logic [1:0]  vec_q, vec_d;
  logic        done_q, done_d;
  logic        accept;
  logic [15:0] vec_base;
  logic [7:0]  new_lo, new_hi_fix;
  logic        page_cross;

  logic [15:0] addr_out;
  logic [7:0]  adl_out, adh_out;
  logic        inc_en, pcl_en, pch_en, adl_en, adh_en;

  pc_branch_calc u_branch_calc (
    .PCLin      (bus.PCLin),
    .PCHin      (bus.PCHin),
    .br_offset  (off_q),
    .new_lo     (new_lo),
    .new_hi_fix (new_hi_fix),
    .page_cross (page_cross)
  );

  assign accept = bus.cmd_valid && (state_q == StIdle);

  always_comb begin
    unique case (vec_q)
      VecNmi:  vec_base = VEC_NMI;
      VecRst:  vec_base = VEC_RST;
      default: vec_base = VEC_IRQ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    tmp_lo_d = tmp_lo_q;
    off_d    = off_q;
    vec_d    = vec_q;
    case (state_q)
      StRstLo: begin
        tmp_lo_d = bus.data_in;
        state_d  = StRstHi;
      end
      StRstHi: state_d = StIdle;
      StIdle: begin
        if (accept) begin
          off_d = bus.br_offset;
          vec_d = bus.vec_sel;
          case (bus.cmd)
            CmdInc:    state_d = StInc;
            CmdJmpAbs: state_d = StFetchLo;
            CmdBranch: state_d = bus.br_taken ? StBrAdd : StIdle;
            CmdVector: state_d = StVecLo;
            default:   state_d = StIdle;
          endcase
        end
      end
      StInc: state_d = StIdle;
      StFetchLo: begin
        tmp_lo_d = bus.data_in;
        state_d  = StFetchHi;
      end
      StFetchHi: state_d = StIdle;
      StBrAdd:   state_d = page_cross ? StBrFix : StIdle;
      StBrFix:   state_d = StIdle;
      StVecLo: begin
        tmp_lo_d = bus.data_in;
        state_d  = StVecHi;
      end
      StVecHi: state_d = StIdle;
      default: state_d = StRstLo;
    endcase
  end

  // Pulse after the last PC update, or right after a no-op acceptance.
  assign done_d = (state_d == StIdle) && ((state_q != StIdle) || accept);

  always_ff @(posedge clock_ph2 or negedge rst) begin
    if (!rst) begin
      state_q  <= StRstLo;
      tmp_lo_q <= '0;
      off_q    <= '0;
      vec_q    <= VecRst;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmp_lo_q <= tmp_lo_d;
      off_q    <= off_d;
      vec_q    <= vec_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    addr_out = {bus.PCHin, bus.PCLin};
    adl_out  = '0;
    adh_out  = '0;
    inc_en   = 1'b0;
    pcl_en   = 1'b0;
    pch_en   = 1'b0;
    adl_en   = 1'b0;
    adh_en   = 1'b0;
    case (state_q)
      StRstLo: begin
        // Hold the PC once out of reset; everything stays off while rst is low.
        addr_out = VEC_RST;
        pcl_en   = rst;
        pch_en   = rst;
      end
      StRstHi: begin
        addr_out = VEC_RST + 16'd1;
        adl_out  = tmp_lo_q;
        adh_out  = bus.data_in;
        adl_en   = 1'b1;
        adh_en   = 1'b1;
      end
      StIdle: begin
        pcl_en = 1'b1;
        pch_en = 1'b1;
      end
      StInc, StFetchLo: begin
        inc_en = 1'b1;
        pcl_en = 1'b1;
        pch_en = 1'b1;
      end
      StFetchHi: begin
        adl_out = tmp_lo_q;
        adh_out = bus.data_in;
        adl_en  = 1'b1;
        adh_en  = 1'b1;
      end
      StBrAdd: begin
        adl_out = new_lo;
        adh_out = bus.PCHin;
        adl_en  = 1'b1;
        adh_en  = 1'b1;
      end
      StBrFix: begin
        adh_out = new_hi_fix;
        adh_en  = 1'b1;
        pcl_en  = 1'b1;
      end
      StVecLo: begin
        addr_out = vec_base;
        pcl_en   = 1'b1;
        pch_en   = 1'b1;
      end
      StVecHi: begin
        addr_out = vec_base + 16'd1;
        adl_out  = tmp_lo_q;
        adh_out  = bus.data_in;
        adl_en   = 1'b1;
        adh_en   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.addr_out  = addr_out;
  assign bus.ADLout    = adl_out;
  assign bus.ADHout    = adh_out;
  assign bus.inc_en    = inc_en;
  assign bus.PCLin_en  = pcl_en;
  assign bus.PCHin_en  = pch_en;
  assign bus.ADLin_en  = adl_en;
  assign bus.ADHin_en  = adh_en;
  assign bus.busy      = (state_q != StIdle);
  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: PC and memory models around the DUT, directed
// scenarios from the test plan, then randomized commands against a PC model.
module tb_pc_sequencer;
  logic clock_ph2 = 1'b0;
  logic rst = 1'b1;
  always #5 clock_ph2 = ~clock_ph2;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock_ph2 (clock_ph2),
    .rst       (rst),
    .bus       (bus)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] pc;
  logic        pc_set = 1'b0;
  logic [15:0] pc_set_val = '0;
  int          errors = 0;
  int          checks = 0;

  assign bus.data_in = mem[bus.addr_out];
  assign bus.PCLin   = pc[7:0];
  assign bus.PCHin   = pc[15:8];

  // Program counter block: increment, per-byte load, or hold.
  always @(posedge clock_ph2) begin
    if (pc_set) pc <= pc_set_val;
    else if (bus.inc_en) pc <= pc + 16'd1;
    else begin
      if (bus.ADLin_en) pc[7:0] <= bus.ADLout;
      if (bus.ADHin_en) pc[15:8] <= bus.ADHout;
    end
  end

  // Advance to the next falling edge and check the per-byte source rule.
  task automatic step();
    @(negedge clock_ph2);
    checks++;
    if ((bus.PCLin_en && bus.ADLin_en) || (bus.PCHin_en && bus.ADHin_en) ||
        (bus.inc_en && !(bus.PCLin_en && bus.PCHin_en))) begin
      errors++;
      $display("FAIL exclusivity: inc=%b PCL=%b PCH=%b ADL=%b ADH=%b, required one source/byte",
               bus.inc_en, bus.PCLin_en, bus.PCHin_en, bus.ADLin_en, bus.ADHin_en);
    end
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_set_val = v;
    pc_set = 1'b1;
    step();
    pc_set = 1'b0;
  endtask

  // Expected final PC and busy-cycle count from the command semantics.
  function automatic void model(input logic [2:0] c, input logic [1:0] vs, input logic tk,
                                input logic [7:0] off, input logic [15:0] p,
                                output logic [15:0] exp_pc, output int exp_cyc);
    logic [15:0] p1, t, v;
    p1 = p + 16'd1;
    exp_pc = p;
    exp_cyc = 0;
    case (c)
      3'd1: begin exp_pc = p1; exp_cyc = 1; end
      3'd2: begin exp_pc = {mem[p1], mem[p]}; exp_cyc = 2; end
      3'd3: if (tk) begin
        t = p + {{8{off[7]}}, off};
        exp_pc = t;
        exp_cyc = (t[15:8] != p[15:8]) ? 2 : 1;
      end
      3'd4: begin
        v = (vs == 2'd0) ? 16'hFFFA : (vs == 2'd1) ? 16'hFFFC : 16'hFFFE;
        t = v + 16'd1;
        exp_pc = {mem[t], mem[v]};
        exp_cyc = 2;
      end
      default: ;
    endcase
  endfunction

  // Issue one command from IDLE and check latency, done pulse and final PC.
  task automatic run_cmd(input logic [2:0] c, input logic [1:0] vs, input logic tk,
                         input logic [7:0] off, input logic [15:0] exp_pc, input int exp_cyc,
                         input string name);
    int n;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1", name, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd = c;
    bus.vec_sel = vs;
    bus.br_taken = tk;
    bus.br_offset = off;
    step();
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 8) begin
      n++;
      step();
    end
    checks += 3;
    if (n != exp_cyc) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d want %0d", name, n, exp_cyc);
    end
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL %s done: got %b want 1", name, bus.done);
    end
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL %s pc: got %h want %h", name, pc, exp_pc);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s done_pulse: got %b want 0", name, bus.done);
    end
  endtask

  task automatic test_reset();
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    #1 rst = 1'b0;
    step();
    checks++;
    if ({bus.addr_out, bus.busy, bus.cmd_ready, bus.done} !== {16'hFFFC, 3'b100}) begin
      errors++;
      $display("FAIL reset_status: got addr=%h busy=%b ready=%b done=%b want FFFC 1 0 0",
               bus.addr_out, bus.busy, bus.cmd_ready, bus.done);
    end
    checks++;
    if ({bus.inc_en, bus.PCLin_en, bus.PCHin_en, bus.ADLin_en, bus.ADHin_en,
         bus.ADLout, bus.ADHout} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b%b%b%b%b ADL=%h ADH=%h want all 0",
               bus.inc_en, bus.PCLin_en, bus.PCHin_en, bus.ADLin_en, bus.ADHin_en,
               bus.ADLout, bus.ADHout);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.addr_out !== 16'hFFFC) begin
      errors++;
      $display("FAIL rst_lo_addr: got %h want FFFC", bus.addr_out);
    end
    step();
    checks++;
    if ({bus.addr_out, bus.ADLin_en, bus.ADHin_en, bus.ADLout, bus.ADHout}
        !== {16'hFFFD, 2'b11, 8'h34, 8'h12}) begin
      errors++;
      $display("FAIL rst_hi_load: got addr=%h en=%b%b ADL=%h ADH=%h want FFFD 11 34 12",
               bus.addr_out, bus.ADLin_en, bus.ADHin_en, bus.ADLout, bus.ADHout);
    end
    step();
    checks++;
    if ({bus.done, bus.cmd_ready, bus.busy, pc} !== {3'b110, 16'h1234}) begin
      errors++;
      $display("FAIL boot_idle: got done=%b ready=%b busy=%b pc=%h want 1 1 0 1234",
               bus.done, bus.cmd_ready, bus.busy, pc);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL boot_done_pulse: got %b want 0", bus.done);
    end
  endtask

  task automatic test_jmp_abs();
    set_pc(16'h0200);
    mem[16'h0200] = 8'h00;
    mem[16'h0201] = 8'hC0;
    bus.cmd_valid = 1'b1;
    bus.cmd = 3'd2;
    step();
    bus.cmd = 3'd1;  // valid stays high with a different command while busy
    checks++;
    if ({bus.addr_out, bus.inc_en, bus.busy} !== {16'h0200, 2'b11}) begin
      errors++;
      $display("FAIL jmp_fetch_lo: got addr=%h inc=%b busy=%b want 0200 1 1",
               bus.addr_out, bus.inc_en, bus.busy);
    end
    step();
    checks++;
    if ({bus.addr_out, bus.ADLin_en, bus.ADHin_en, bus.ADLout, bus.ADHout, bus.busy}
        !== {16'h0201, 2'b11, 8'h00, 8'hC0, 1'b1}) begin
      errors++;
      $display("FAIL jmp_fetch_hi: got addr=%h en=%b%b ADL=%h ADH=%h want 0201 11 00 C0",
               bus.addr_out, bus.ADLin_en, bus.ADHin_en, bus.ADLout, bus.ADHout);
    end
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.busy, bus.done, pc} !== {2'b01, 16'hC000}) begin
      errors++;
      $display("FAIL jmp_end: got busy=%b done=%b pc=%h want 0 1 C000", bus.busy, bus.done, pc);
    end
    step();
    checks++;
    if ({bus.done, pc} !== {1'b0, 16'hC000}) begin
      errors++;
      $display("FAIL jmp_held_valid: got done=%b pc=%h want 0 C000", bus.done, pc);
    end
  endtask

  task automatic test_branch();
    set_pc(16'h02F0);
    bus.cmd_valid = 1'b1;
    bus.cmd = 3'd3;
    bus.br_taken = 1'b1;
    bus.br_offset = 8'h20;
    step();
    bus.cmd_valid = 1'b0;
    checks++;
    if ({bus.ADLin_en, bus.ADHin_en, bus.ADLout, bus.ADHout} !== {2'b11, 8'h10, 8'h02}) begin
      errors++;
      $display("FAIL br_add: got en=%b%b ADL=%h ADH=%h want 11 10 02",
               bus.ADLin_en, bus.ADHin_en, bus.ADLout, bus.ADHout);
    end
    step();
    checks++;
    if ({bus.ADHin_en, bus.PCLin_en, bus.ADLin_en, bus.PCHin_en, bus.ADHout, pc}
        !== {4'b1100, 8'h03, 16'h0210}) begin
      errors++;
      $display("FAIL br_fix: got ADH_en=%b PCL_en=%b ADH=%h pc=%h want 1 1 03 0210",
               bus.ADHin_en, bus.PCLin_en, bus.ADHout, pc);
    end
    step();
    checks++;
    if ({bus.busy, bus.done, pc} !== {2'b01, 16'h0310}) begin
      errors++;
      $display("FAIL br_end: got busy=%b done=%b pc=%h want 0 1 0310", bus.busy, bus.done, pc);
    end
    step();
    set_pc(16'h0305);
    run_cmd(3'd3, 2'd0, 1'b1, 8'hF0, 16'h02F5, 2, "br_back_cross");
    set_pc(16'h0310);
    run_cmd(3'd3, 2'd0, 1'b1, 8'h05, 16'h0315, 1, "br_same_page");
  endtask

  task automatic test_not_taken();
    set_pc(16'h1234);
    run_cmd(3'd3, 2'd0, 1'b0, 8'h55, 16'h1234, 0, "br_not_taken");
    run_cmd(3'd6, 2'd0, 1'b1, 8'h55, 16'h1234, 0, "illegal_cmd");
    run_cmd(3'd0, 2'd0, 1'b1, 8'h55, 16'h1234, 0, "nop");
  endtask

  task automatic test_vector();
    mem[16'hFFFA] = 8'h00;
    mem[16'hFFFB] = 8'h80;
    set_pc(16'h4444);
    run_cmd(3'd4, 2'd0, 1'b0, 8'h00, 16'h8000, 2, "vec_nmi");
  endtask

  task automatic test_back_to_back();
    set_pc(16'hFFFE);
    run_cmd(3'd1, 2'd0, 1'b0, 8'h00, 16'hFFFF, 1, "inc_1");
    run_cmd(3'd1, 2'd0, 1'b0, 8'h00, 16'h0000, 1, "inc_wrap");
    run_cmd(3'd3, 2'd0, 1'b1, 8'hFF, 16'hFFFF, 2, "br_back_wrap");
  endtask

  task automatic test_reset_abort();
    set_pc(16'h4567);
    bus.cmd_valid = 1'b1;
    bus.cmd = 3'd4;
    bus.vec_sel = 2'd0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    checks++;
    if ({bus.addr_out, bus.ADLin_en} !== {16'hFFFB, 1'b1}) begin
      errors++;
      $display("FAIL abort_vec_hi: got addr=%h ADL_en=%b want FFFB 1", bus.addr_out, bus.ADLin_en);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.inc_en, bus.PCLin_en, bus.PCHin_en, bus.ADLin_en, bus.ADHin_en, bus.busy,
         bus.addr_out} !== {6'b000001, 16'hFFFC}) begin
      errors++;
      $display("FAIL abort_drop: got en=%b%b%b%b%b busy=%b addr=%h want 00000 1 FFFC",
               bus.inc_en, bus.PCLin_en, bus.PCHin_en, bus.ADLin_en, bus.ADHin_en,
               bus.busy, bus.addr_out);
    end
    step();
    checks++;
    if (pc !== 16'h4567) begin
      errors++;
      $display("FAIL abort_no_load: got pc=%h want 4567", pc);
    end
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({bus.done, bus.busy, pc} !== {2'b10, mem[16'hFFFD], mem[16'hFFFC]}) begin
      errors++;
      $display("FAIL abort_reboot: got done=%b busy=%b pc=%h want 1 0 %h%h",
               bus.done, bus.busy, pc, mem[16'hFFFD], mem[16'hFFFC]);
    end
    step();
  endtask

  task automatic test_random();
    logic [2:0]  c;
    logic [1:0]  vs;
    logic        tk;
    logic [7:0]  off;
    logic [15:0] p, exp_pc;
    int          exp_cyc;
    for (int i = 0; i < 60; i++) begin
      c = 3'($urandom_range(0, 7));
      vs = 2'($urandom_range(0, 3));
      tk = 1'($urandom);
      off = 8'($urandom);
      p = 16'($urandom);
      set_pc(p);
      model(c, vs, tk, off, p, exp_pc, exp_cyc);
      run_cmd(c, vs, tk, off, exp_pc, exp_cyc, $sformatf("rand%0d_cmd%0d", i, c));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd = 3'd0;
    bus.vec_sel = 2'd0;
    bus.br_taken = 1'b0;
    bus.br_offset = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_jmp_abs();
    test_branch();
    test_not_taken();
    test_vector();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
